// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM: counter mode constants and the
// centre-aligned counter direction type.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared timebase: clock prescaler, period counter (edge or centre aligned),
// period boundary detection and the registered period-start pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] period_act,
    input  logic             mode_act,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary,
    output logic             period_tick
);

    logic [PRE_W-1:0] pre_cnt;
    dir_t             dir;
    dir_t             dir_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tick;

    // Next counter/direction and boundary; a period of 0 pins cnt at 0 and
    // makes every tick a boundary because cnt == period_act always holds.
    always_comb begin
        tick     = en && (pre_cnt == prescale);
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (tick) begin
            if (mode_act == MODE_EDGE) begin
                if (cnt == period_act) begin
                    boundary = 1'b1;
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end else if (dir == DIR_UP) begin
                if (cnt == period_act) begin
                    if (period_act <= WIDTH'(1)) begin
                        boundary = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        dir_nxt = DIR_DOWN;
                        cnt_nxt = cnt - WIDTH'(1);
                    end
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end else begin
                if (cnt == WIDTH'(1)) begin
                    boundary = 1'b1;
                    cnt_nxt  = '0;
                    dir_nxt  = DIR_UP;
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end
        end
    end

    // Counter state; dropping en parks everything so a restart begins a fresh period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
        end else if (!en) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + PRE_W'(1);
            cnt         <= cnt_nxt;
            dir         <= dir_nxt;
            period_tick <= boundary;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared timebase, shadowed period/mode/duty registers
// that switch only at period boundaries, and per-channel registered comparators.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int PRE_W    = 8,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PRE_W-1:0]    prescale,
    input  logic [WIDTH-1:0]    period,
    input  logic                center_mode,
    input  logic [CHANNELS-1:0] polarity,
    input  logic                duty_wr,
    input  logic [SEL_W-1:0]    duty_sel,
    input  logic [WIDTH-1:0]    duty_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [WIDTH-1:0] cnt;
    logic             boundary;
    logic [WIDTH-1:0] period_act;
    logic             mode_act;
    logic             wr_hit;
    logic             load_act;

    // Out-of-range channel indices (possible when CHANNELS is not a power of two) are dropped.
    assign wr_hit   = duty_wr && (32'(duty_sel) < CHANNELS);
    // While disabled the active copies follow their sources every cycle.
    assign load_act = !en || boundary;

    pwm_timebase #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .prescale    (prescale),
        .period_act  (period_act),
        .mode_act    (mode_act),
        .cnt         (cnt),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    // Period and mode shadow: sampled only at a boundary so a period is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_act <= '0;
            mode_act   <= MODE_EDGE;
        end else if (load_act) begin
            period_act <= period;
            mode_act   <= center_mode;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] duty_pend;
        logic [WIDTH-1:0] duty_act;
        logic             sel_hit;
        logic             out_p1;

        assign sel_hit    = wr_hit && (32'(duty_sel) == i);
        assign pwm_out[i] = out_p1;

        // Duty shadow: a write landing on a boundary bypasses pending so the new value wins.
        always_ff @(posedge clk) begin
            if (rst) begin
                duty_pend <= '0;
                duty_act  <= '0;
            end else begin
                if (sel_hit) begin
                    duty_pend <= duty_data;
                end
                if (load_act) begin
                    duty_act <= sel_hit ? duty_data : duty_pend;
                end
            end
        end

        // Stage p0 -> p1: compare cnt against active duty, apply polarity, register output.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_p1 <= 1'b0;
            end else begin
                out_p1 <= en ? ((cnt < duty_act) ^ polarity[i]) : polarity[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: reset, edge/centre duty patterns,
// shadowed updates, out-of-range writes and disable/re-enable behaviour.
module tb_pwm_multi_channel;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int PRE_W    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [PRE_W-1:0]    prescale;
    logic [WIDTH-1:0]    period;
    logic                center_mode;
    logic [CHANNELS-1:0] polarity;
    logic                duty_wr;
    logic [1:0]          duty_sel;
    logic [WIDTH-1:0]    duty_data;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_tick;

    // three-channel instance, used where duty_sel can be out of range
    logic             en3;
    logic [PRE_W-1:0] prescale3;
    logic [WIDTH-1:0] period3;
    logic             center3;
    logic [2:0]       polarity3;
    logic             duty_wr3;
    logic [1:0]       duty_sel3;
    logic [WIDTH-1:0] duty_data3;
    logic [2:0]       pwm_out3;
    logic             period_tick3;

    int checks   = 0;
    int failures = 0;

    logic [CHANNELS-1:0] s_pwm  [0:63];
    logic                s_tick [0:63];

    always #5 clk = ~clk;

    pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst(rst), .en(en), .prescale(prescale), .period(period),
        .center_mode(center_mode), .polarity(polarity), .duty_wr(duty_wr),
        .duty_sel(duty_sel), .duty_data(duty_data), .pwm_out(pwm_out),
        .period_tick(period_tick)
    );

    pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(3), .PRE_W(PRE_W)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .prescale(prescale3), .period(period3),
        .center_mode(center3), .polarity(polarity3), .duty_wr(duty_wr3),
        .duty_sel(duty_sel3), .duty_data(duty_data3), .pwm_out(pwm_out3),
        .period_tick(period_tick3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int start, input int n);
        for (int j = 0; j < n; j++) begin
            step();
            s_pwm[start + j]  = pwm_out;
            s_tick[start + j] = period_tick;
        end
    endtask

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int j = 0; j < 64 && !found; j++) begin
            step();
            if (period_tick === 1'b1) found = 1'b1;
        end
    endtask

    task automatic write_duty(input logic [1:0] sel, input logic [WIDTH-1:0] data);
        duty_wr   = 1'b1;
        duty_sel  = sel;
        duty_data = data;
        step();
        duty_wr = 1'b0;
    endtask

    function automatic logic [31:0] chan_bits(input int ch, input int start, input int n);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[j] = s_pwm[start + j][ch];
        return r;
    endfunction

    function automatic logic [31:0] tick_bits(input int start, input int n);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[j] = s_tick[start + j];
        return r;
    endfunction

    task automatic test_reset();
        logic [31:0] got;
        rst = 1'b1; en = 1'b1; prescale = '0; period = 8'd9; center_mode = 1'b0;
        polarity = 4'hF; duty_wr = 1'b1; duty_sel = 2'd0; duty_data = 8'd7;
        en3 = 1'b1; prescale3 = '0; period3 = '0; center3 = 1'b0; polarity3 = '0;
        duty_wr3 = 1'b0; duty_sel3 = '0; duty_data3 = '0;
        step();
        step();
        checks++;
        if (pwm_out !== 4'b0000) begin
            failures++; $display("FAIL reset_pwm got=%b want=%b", pwm_out, 4'b0000);
        end
        checks++;
        if (period_tick !== 1'b0) begin
            failures++; $display("FAIL reset_tick got=%b want=0", period_tick);
        end
        checks++;
        if (pwm_out3 !== 3'b000) begin
            failures++; $display("FAIL reset_pwm3 got=%b want=000", pwm_out3);
        end
        rst = 1'b0; duty_wr = 1'b0; polarity = 4'h0;
        capture(0, 12);
        got = chan_bits(0, 0, 12);
        checks++;
        if (got !== 32'h0) begin
            failures++; $display("FAIL reset_write_dropped got=%h want=%h", got, 32'h0);
        end
        got = tick_bits(0, 12);
        checks++;
        if (got !== 32'h401) begin
            failures++; $display("FAIL reset_first_ticks got=%h want=%h", got, 32'h401);
        end
    endtask

    task automatic test_run();
        bit found;
        logic [31:0] got;
        write_duty(2'd0, 8'd3);
        wait_tick(found);
        checks++;
        if (found !== 1'b1) begin
            failures++; $display("FAIL run_sync got=%b want=1", found);
        end
        capture(0, 10);
        got = chan_bits(0, 0, 10);
        checks++;
        if (got !== 32'h007) begin
            failures++; $display("FAIL run_d3 got=%h want=%h", got, 32'h007);
        end
        got = tick_bits(0, 10);
        checks++;
        if (got !== 32'h200) begin
            failures++; $display("FAIL run_tick_period got=%h want=%h", got, 32'h200);
        end
    endtask

    task automatic test_extremes();
        bit found;
        logic [31:0] got;
        write_duty(2'd1, 8'd0);
        write_duty(2'd2, 8'd10);
        write_duty(2'd3, 8'd255);
        wait_tick(found);
        checks++;
        if (found !== 1'b1) begin
            failures++; $display("FAIL ext_sync got=%b want=1", found);
        end
        capture(0, 10);
        polarity = 4'b1000;
        capture(10, 10);
        got = chan_bits(1, 0, 20);
        checks++;
        if (got !== 32'h0) begin
            failures++; $display("FAIL ext_d0 got=%h want=%h", got, 32'h0);
        end
        got = chan_bits(2, 0, 20);
        checks++;
        if (got !== 32'hFFFFF) begin
            failures++; $display("FAIL ext_d_p_plus1 got=%h want=%h", got, 32'hFFFFF);
        end
        got = chan_bits(3, 0, 10);
        checks++;
        if (got !== 32'h3FF) begin
            failures++; $display("FAIL ext_d255 got=%h want=%h", got, 32'h3FF);
        end
        got = chan_bits(3, 10, 10);
        checks++;
        if (got !== 32'h0) begin
            failures++; $display("FAIL ext_d255_active_low got=%h want=%h", got, 32'h0);
        end
    endtask

    task automatic test_shadow();
        bit found;
        logic [31:0] got;
        polarity = 4'h0;
        wait_tick(found);
        checks++;
        if (found !== 1'b1) begin
            failures++; $display("FAIL shadow_sync got=%b want=1", found);
        end
        capture(0, 2);
        duty_wr = 1'b1; duty_sel = 2'd0; duty_data = 8'd7;
        capture(2, 1);
        duty_wr = 1'b0;
        capture(3, 17);
        got = chan_bits(0, 0, 20);
        checks++;
        if (got !== {12'h0, 10'b0001111111, 10'b0000000111}) begin
            failures++;
            $display("FAIL shadow_d3_then_d7 got=%h want=%h", got, {12'h0, 10'b0001111111, 10'b0000000111});
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        logic [31:0] got;
        wait_tick(found);
        checks++;
        if (found !== 1'b1) begin
            failures++; $display("FAIL b2b_sync got=%b want=1", found);
        end
        capture(0, 9);
        duty_wr = 1'b1; duty_sel = 2'd0; duty_data = 8'd5;
        capture(9, 1);
        duty_wr = 1'b0;
        capture(10, 10);
        got = chan_bits(0, 0, 20);
        checks++;
        if (got !== {12'h0, 10'b0000011111, 10'b0001111111}) begin
            failures++;
            $display("FAIL b2b_write_on_boundary got=%h want=%h", got, {12'h0, 10'b0000011111, 10'b0001111111});
        end
        got = tick_bits(0, 20);
        checks++;
        if (got !== {12'h0, 10'b1000000000, 10'b1000000000}) begin
            failures++;
            $display("FAIL b2b_ticks got=%h want=%h", got, {12'h0, 10'b1000000000, 10'b1000000000});
        end
    endtask

    task automatic test_out_of_range();
        duty_wr3 = 1'b1; duty_sel3 = 2'd3; duty_data3 = 8'd5;
        step();
        duty_wr3 = 1'b0;
        step();
        step();
        checks++;
        if (pwm_out3 !== 3'b000) begin
            failures++; $display("FAIL oor_ignored got=%b want=000", pwm_out3);
        end
        checks++;
        if (period_tick3 !== 1'b1) begin
            failures++; $display("FAIL p0_tick_every_clock got=%b want=1", period_tick3);
        end
        duty_wr3 = 1'b1; duty_sel3 = 2'd2; duty_data3 = 8'd1;
        step();
        duty_wr3 = 1'b0;
        step();
        step();
        checks++;
        if (pwm_out3 !== 3'b100) begin
            failures++; $display("FAIL in_range_write got=%b want=100", pwm_out3);
        end
    endtask

    task automatic test_center();
        bit found;
        logic [31:0] got;
        period = 8'd4; center_mode = 1'b1; prescale = 8'd1;
        write_duty(2'd0, 8'd2);
        wait_tick(found);
        checks++;
        if (found !== 1'b1) begin
            failures++; $display("FAIL center_sync got=%b want=1", found);
        end
        capture(0, 16);
        got = chan_bits(0, 0, 16);
        checks++;
        if (got !== 32'hC00F) begin
            failures++; $display("FAIL center_d2 got=%h want=%h", got, 32'hC00F);
        end
        got = tick_bits(0, 16);
        checks++;
        if (got !== 32'h8000) begin
            failures++; $display("FAIL center_tick_period got=%h want=%h", got, 32'h8000);
        end
        got = chan_bits(2, 0, 16);
        checks++;
        if (got !== 32'hFFFF) begin
            failures++; $display("FAIL center_full got=%h want=%h", got, 32'hFFFF);
        end
    endtask

    task automatic test_disable();
        bit found;
        logic [31:0] got;
        period = 8'd9; center_mode = 1'b0; prescale = 8'd0; polarity = 4'b0001;
        write_duty(2'd0, 8'd3);
        wait_tick(found);
        checks++;
        if (found !== 1'b1) begin
            failures++; $display("FAIL dis_sync got=%b want=1", found);
        end
        capture(0, 4);
        en = 1'b0;
        step();
        checks++;
        if (pwm_out !== 4'b0001) begin
            failures++; $display("FAIL dis_inactive got=%b want=%b", pwm_out, 4'b0001);
        end
        checks++;
        if (dut.u_timebase.cnt !== 8'd0) begin
            failures++; $display("FAIL dis_cnt_cleared got=%0d want=0", dut.u_timebase.cnt);
        end
        period = 8'd4;
        capture(0, 3);
        got = chan_bits(2, 0, 3) | tick_bits(0, 3);
        checks++;
        if (got !== 32'h0) begin
            failures++; $display("FAIL dis_hold got=%h want=%h", got, 32'h0);
        end
        en = 1'b1;
        capture(0, 5);
        got = chan_bits(0, 0, 5);
        checks++;
        if (got !== 32'h18) begin
            failures++; $display("FAIL reen_pwm got=%h want=%h", got, 32'h18);
        end
        got = tick_bits(0, 5);
        checks++;
        if (got !== 32'h10) begin
            failures++; $display("FAIL reen_tick got=%h want=%h", got, 32'h10);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_extremes();
        test_shadow();
        test_back_to_back();
        test_out_of_range();
        test_center();
        test_disable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
